// File: rtl/rv_ctrl_pkg.sv
// Shared types and select codes for the RV32I multicycle control unit.
// Imported by the main FSM and the ALU decoder.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } aluop_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [2:0] SRCB_REG    = 3'b000;
  localparam logic [2:0] SRCB_IMM    = 3'b010;
  localparam logic [2:0] SRCB_FOUR   = 3'b100;
  localparam logic [2:0] SRCB_TWELVE = 3'b110;
  localparam logic [2:0] SRCB_ALUOUT = 3'b111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/rv_multicycle_ctrl_alu_decoder.sv
// Maps the FSM's ALU-op request plus funct fields to an ALU control code.
// Flags funct3 values the datapath does not implement.
module rv_alu_decoder
  import rv_ctrl_pkg::*;
(
  input  aluop_t     alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       rtype_i,
  output logic [2:0] alu_control_o,
  output logic       illegal_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    illegal_o     = 1'b0;
    case (alu_op_i)
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000: begin
            // Only R-type encodes sub; addi ignores instr[30]
            if (rtype_i && funct7b5_i)
              alu_control_o = ALU_SUB;
          end
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: illegal_o = 1'b1;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Main control FSM for the RV32I multicycle datapath.
// Moore decode of state, with a memory-ready handshake and illegal-op trap.
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH,
  parameter bit     TRAP_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_req,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [2:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal_instr,
  output logic [3:0] state_o
);

  state_t state_q, state_d;
  aluop_t alu_op;
  logic   rtype;
  logic   funct_bad;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= RESET_STATE;
    else          state_q <= state_d;
  end

  always_comb begin
    alu_op = ALUOP_ADD;
    rtype  = 1'b0;
    case (state_q)
      S_EXECR: begin
        alu_op = ALUOP_FUNCT;
        rtype  = 1'b1;
      end
      S_EXECI: alu_op = ALUOP_FUNCT;
      S_BEQ:   alu_op = ALUOP_SUB;
      default: alu_op = ALUOP_ADD;
    endcase
  end

  rv_alu_decoder u_alu_dec (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .rtype_i       (rtype),
    .alu_control_o (alu_control),
    .illegal_o     (funct_bad)
  );

  always_comb begin
    state_d       = S_FETCH;
    pc_write      = 1'b0;
    adr_src       = 1'b0;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_REG;
    imm_src       = IMM_I;
    illegal_instr = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        // PC only advances together with a captured instruction
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        state_d    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_BEQ:            state_d = S_BEQ;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_d   = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
        state_d   = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_REG;
        state_d   = funct_bad ? S_TRAP : S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_I;
        state_d   = funct_bad ? S_TRAP : S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_REG;
        result_src = RES_ALUOUT;
        pc_write   = zero;
      end
      S_JAL: begin
        // PC takes the target latched in DECODE while ALU forms OldPC+4
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        imm_src    = IMM_J;
        pc_write   = 1'b1;
        state_d    = S_ALUWB;
      end
      S_TRAP: begin
        illegal_instr = 1'b1;
        state_d       = TRAP_STICKY ? S_TRAP : S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Scoreboard bench for rv_multicycle_ctrl: directed instruction flows,
// expected per-cycle output vectors queued by stimulus, checked by a monitor.
module tb_rv_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_req, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, imm_src;
  logic [2:0] alu_src_b, alu_control;
  logic       illegal_instr;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  rv_multicycle_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .adr_src       (adr_src),
    .mem_req       (mem_req),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .result_src    (result_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .imm_src       (imm_src),
    .alu_control   (alu_control),
    .illegal_instr (illegal_instr),
    .state_o       (state_o)
  );

  // {state, pcw adr mreq mw irw rw, res, srca, srcb, imm, aluctl, ill}
  localparam logic [22:0] E_FETCH_R =
    {4'd0, 6'b101010, 2'b10, 2'b00, 3'b100, 2'b00, 3'b000, 1'b0};
  localparam logic [22:0] E_FETCH_W =
    {4'd0, 6'b001000, 2'b10, 2'b00, 3'b100, 2'b00, 3'b000, 1'b0};
  localparam logic [22:0] E_DEC =
    {4'd1, 6'b000000, 2'b00, 2'b01, 3'b010, 2'b10, 3'b000, 1'b0};
  localparam logic [22:0] E_MADR_L =
    {4'd2, 6'b000000, 2'b00, 2'b10, 3'b010, 2'b00, 3'b000, 1'b0};
  localparam logic [22:0] E_MADR_S =
    {4'd2, 6'b000000, 2'b00, 2'b10, 3'b010, 2'b01, 3'b000, 1'b0};
  localparam logic [22:0] E_MRD =
    {4'd3, 6'b011000, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 1'b0};
  localparam logic [22:0] E_MWB =
    {4'd4, 6'b000001, 2'b01, 2'b00, 3'b000, 2'b00, 3'b000, 1'b0};
  localparam logic [22:0] E_MWR =
    {4'd5, 6'b011100, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 1'b0};
  localparam logic [22:0] E_EXR_ADD =
    {4'd6, 6'b000000, 2'b00, 2'b10, 3'b000, 2'b00, 3'b000, 1'b0};
  localparam logic [22:0] E_EXR_SUB =
    {4'd6, 6'b000000, 2'b00, 2'b10, 3'b000, 2'b00, 3'b001, 1'b0};
  localparam logic [22:0] E_EXI_SLT =
    {4'd7, 6'b000000, 2'b00, 2'b10, 3'b010, 2'b00, 3'b101, 1'b0};
  localparam logic [22:0] E_EXI_OR =
    {4'd7, 6'b000000, 2'b00, 2'b10, 3'b010, 2'b00, 3'b011, 1'b0};
  localparam logic [22:0] E_EXI_ADD =
    {4'd7, 6'b000000, 2'b00, 2'b10, 3'b010, 2'b00, 3'b000, 1'b0};
  localparam logic [22:0] E_ALUWB =
    {4'd8, 6'b000001, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 1'b0};
  localparam logic [22:0] E_BEQ_T =
    {4'd9, 6'b100000, 2'b00, 2'b10, 3'b000, 2'b00, 3'b001, 1'b0};
  localparam logic [22:0] E_BEQ_N =
    {4'd9, 6'b000000, 2'b00, 2'b10, 3'b000, 2'b00, 3'b001, 1'b0};
  localparam logic [22:0] E_JAL =
    {4'd10, 6'b100000, 2'b00, 2'b01, 3'b100, 2'b11, 3'b000, 1'b0};
  localparam logic [22:0] E_TRAP =
    {4'd11, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 1'b1};

  logic [22:0] exp_q[$];
  logic [22:0] act;
  logic [22:0] mon_e;
  int checks = 0;
  int errors = 0;

  assign act = {state_o, pc_write, adr_src, mem_req, mem_write,
                ir_write, reg_write, result_src, alu_src_a,
                alu_src_b, imm_src, alu_control, illegal_instr};

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (act !== mon_e) begin
        errors++;
        $display("FAIL chk%0d t=%0t state got %0d exp %0d vec got %h exp %h",
                 checks, $time, act[22:19], mon_e[22:19], act, mon_e);
      end
    end
  end

  task automatic step(input logic mr, input logic z, input logic [22:0] e);
    mem_ready = mr;
    zero      = z;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [6:0] op, input logic [2:0] f3,
                       input logic f7);
    opcode   = op;
    funct3   = f3;
    funct7b5 = f7;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    zero      = 1'b0;
    instr(7'b0110011, 3'b000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // add x3,x1,x2
    step(1, 0, E_FETCH_R);
    step(1, 0, E_DEC);
    step(1, 0, E_EXR_ADD);
    step(1, 0, E_ALUWB);

    // sub
    instr(7'b0110011, 3'b000, 1'b1);
    step(1, 0, E_FETCH_R);
    step(1, 0, E_DEC);
    step(1, 0, E_EXR_SUB);
    step(1, 0, E_ALUWB);

    // slti, ori (instr[30] set), addi (instr[30] set, no sub)
    instr(7'b0010011, 3'b010, 1'b0);
    step(1, 0, E_FETCH_R);
    step(1, 0, E_DEC);
    step(1, 0, E_EXI_SLT);
    step(1, 0, E_ALUWB);
    instr(7'b0010011, 3'b110, 1'b1);
    step(1, 0, E_FETCH_R);
    step(1, 0, E_DEC);
    step(1, 0, E_EXI_OR);
    step(1, 0, E_ALUWB);
    instr(7'b0010011, 3'b000, 1'b1);
    step(1, 0, E_FETCH_R);
    step(1, 0, E_DEC);
    step(1, 0, E_EXI_ADD);
    step(1, 0, E_ALUWB);

    // lw with a fetch stall and 3 wait cycles in MEMREAD
    instr(7'b0000011, 3'b010, 1'b0);
    step(0, 0, E_FETCH_W);
    step(1, 0, E_FETCH_R);
    step(1, 0, E_DEC);
    step(1, 0, E_MADR_L);
    step(0, 0, E_MRD);
    step(0, 0, E_MRD);
    step(0, 0, E_MRD);
    step(1, 0, E_MRD);
    step(1, 0, E_MWB);

    // beq taken, then not taken
    instr(7'b1100011, 3'b000, 1'b0);
    step(1, 0, E_FETCH_R);
    step(1, 0, E_DEC);
    step(1, 1, E_BEQ_T);
    step(1, 0, E_FETCH_R);
    step(1, 0, E_DEC);
    step(1, 0, E_BEQ_N);

    // jal
    instr(7'b1101111, 3'b000, 1'b0);
    step(1, 0, E_FETCH_R);
    step(1, 0, E_DEC);
    step(1, 0, E_JAL);
    step(1, 0, E_ALUWB);

    // sw with mem_ready delayed 2 cycles
    instr(7'b0100011, 3'b010, 1'b0);
    step(1, 0, E_FETCH_R);
    step(1, 0, E_DEC);
    step(1, 0, E_MADR_S);
    step(0, 0, E_MWR);
    step(0, 0, E_MWR);
    step(1, 0, E_MWR);
    instr(7'b0110011, 3'b001, 1'b0);
    step(1, 0, E_FETCH_R);

    // unsupported funct3 in R-type traps from EXECR
    step(1, 0, E_DEC);
    step(1, 0, E_EXR_ADD);
    step(1, 0, E_TRAP);
    step(1, 0, E_TRAP);
    step(1, 0, E_TRAP);
    do_reset();

    // unsupported opcode: sticky trap
    instr(7'b1111111, 3'b000, 1'b0);
    step(1, 0, E_FETCH_R);
    step(1, 0, E_DEC);
    for (int i = 0; i < 10; i++) step(1, 0, E_TRAP);
    do_reset();

    // reset asserted mid-MEMWRITE
    instr(7'b0100011, 3'b010, 1'b0);
    step(1, 0, E_FETCH_R);
    step(1, 0, E_DEC);
    step(1, 0, E_MADR_S);
    reset_n = 1'b0;
    step(0, 0, E_MWR);
    step(0, 0, E_FETCH_W);
    reset_n = 1'b1;
    step(1, 0, E_FETCH_R);
    step(1, 0, E_DEC);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
Main control FSM for the RV32I multicycle datapath. It sequences fetch, decode, execute, memory and writeback, and drives every datapath select, including the ALU source-B select. It adds a memory-ready handshake so the datapath tolerates multi-cycle memory. It traps on unsupported opcodes.

Parameters:
RESET_STATE, S_FETCH, state entered on reset
TRAP_STICKY, 1, 1: the TRAP state holds until reset; 0: TRAP returns to FETCH after one cycle

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  synchronous active-low reset
opcode  in  7  instr[6:0] from the instruction register
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU zero flag, valid in the BEQ state
mem_ready  in  1  memory has completed the current access this cycle
pc_write  out  1  load PC
adr_src  out  1  0=PC, 1=ALUOut as memory address
mem_req  out  1  memory access request
mem_write  out  1  store strobe
ir_write  out  1  load IR and OldPC
reg_write  out  1  register file write
result_src  out  2  00=ALUOut, 01=Data, 10=ALUResult
alu_src_a  out  2  00=PC, 01=OldPC, 10=A(rs1)
alu_src_b  out  3  000=B(rs2), 010=ImmExt, 100=const 4; codes 110 and 111 are never driven
imm_src  out  2  00=I, 01=S, 10=B, 11=J
alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
illegal_instr  out  1  high while in TRAP
state_o  out  4  current state, debug only

Behaviour:
- State register updates on posedge clk. When reset_n=0 at an edge, state goes to FETCH and takes priority over everything, including mid-access.
- Outputs are a Moore decode of state; alu_control additionally decodes funct3/funct7b5. Default for every output is 0 unless listed below.
- In reset and on the first post-reset cycle, all strobes are 0 except that FETCH decode applies.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=100, alu_control=add, result_src=10.
  - If mem_ready=1: ir_write=1 and pc_write=1 in that same cycle, then go to DECODE.
  - Else stay in FETCH with ir_write=pc_write=0, so the PC never advances without an instruction.
- DECODE: alu_src_a=01, alu_src_b=010, imm_src=10, alu_control=add (precomputes the branch/JAL target). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - anything else -> TRAP
- MEMADR: alu_src_a=10, alu_src_b=010, add. imm_src=00 for loads, 01 for stores. Loads go to MEMREAD, stores go to MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. Stay until mem_ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, then go to FETCH.
- MEMWRITE: mem_req=1, adr_src=1, mem_write=1 held until mem_ready, then go to FETCH. mem_write must drop in the cycle after the mem_ready cycle.
- EXECR: alu_src_a=10, alu_src_b=000, ALU op from funct. Next state ALUWB.
- EXECI: alu_src_a=10, alu_src_b=010, imm_src=00, ALU op from funct (sub is never selected for I-type). Next state ALUWB.
- ALUWB: result_src=00, reg_write=1, then go to FETCH.
- BEQ: alu_src_a=10, alu_src_b=000, sub, result_src=00. pc_write=zero. Next state FETCH.
- JAL: alu_src_a=01, alu_src_b=100, add, result_src=00, pc_write=1, imm_src=11. Then go to ALUWB (which writes rd=OldPC+4). The target is taken from ALUOut via result_src=00 before the ALU overwrites it; implement it as a single state with result_src=00 for the PC path.
- ALU function decode:
  - funct3 000: sub if R-type and funct7b5=1, else add
  - funct3 010: slt
  - funct3 110: or
  - funct3 111: and
  - any other funct3 in EXECR/EXECI -> TRAP on the next edge instead of ALUWB
- TRAP: illegal_instr=1, no strobes. With TRAP_STICKY=1 it stays until reset; with 0 it goes to FETCH.
- Invariants: pc_write and mem_write are never both high; reg_write is never high in FETCH or DECODE.
- Unreachable state encodings go to FETCH.

Decomposition:
- Package rv_ctrl_pkg holds:
  - state_t enum
  - opcode constants (OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL, OP_BEQ)
  - select-code constants: SRCB_REG=3'b000, SRCB_IMM=3'b010, SRCB_FOUR=3'b100, SRCB_TWELVE=3'b110, SRCB_ALUOUT=3'b111
  - the alu_control and imm_src codes
- One sub-module, rv_alu_decoder (ALU-op + funct3/funct7b5 -> alu_control, plus an illegal flag).

Test Plan:
- Reset held low 3 cycles with mem_ready=1, then released -> state_o=FETCH, ir_write=1, pc_write=1 on the first post-reset cycle, alu_src_b=100.
- add x3,x1,x2 (opcode 0110011, f3 000, f7b5 0) with mem_ready=1 -> FETCH, DECODE, EXECR (alu_src_b=000, alu_control=000), ALUWB (reg_write=1) = 4 cycles.
- lw with mem_ready low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles with mem_req=1 and adr_src=1, then MEMWB with result_src=01, reg_write=1; total 5+3 cycles.
- beq with zero=1, then again with zero=0 -> pc_write=1 in BEQ for the first, 0 for the second, next state FETCH; DECODE shows alu_src_a=01, alu_src_b=010.
- opcode 1111111 -> TRAP after DECODE, illegal_instr=1 sticky for 10 cycles. Deasserting reset_n low mid-MEMWRITE -> FETCH on the next edge with mem_write=0.
- sw with mem_ready delayed 2 cycles -> mem_write high for exactly 3 cycles, low in the following FETCH.
